// File: rtl/lcd_nibble_driver_pkg.sv
// Shared timing constants, HD44780 command codes, state encodings and the
// byte-writer request type for the 4-bit LCD driver.
package lcd_nibble_driver_pkg;

  // Cycle counts at 50 MHz
  localparam int unsigned T_PWR   = 750000; // 15 ms power-on settle
  localparam int unsigned T_4MS   = 205000; // 4.1 ms after first 0x3
  localparam int unsigned T_100US = 5000;   // 100 us after second 0x3
  localparam int unsigned T_40US  = 2000;   // 40 us generic command time
  localparam int unsigned T_1MS64 = 82000;  // 1.64 ms clear/home time
  localparam int unsigned T_GAP   = 50;     // 1 us between nibbles of a byte
  localparam int unsigned T_EPW   = 12;     // E high pulse width
  localparam int unsigned T_SU    = 2;      // setup before E / hold after E

  localparam int unsigned CW = 20;          // wait counter width

  localparam logic [7:0] CMD_FUNC  = 8'h28; // 4-bit, 2 lines, 5x8
  localparam logic [7:0] CMD_ENTRY = 8'h06; // increment, no shift
  localparam logic [7:0] CMD_DISP  = 8'h0C; // display on, cursor off
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ADDR  = 8'h80; // set DDRAM address

  typedef enum logic [2:0] {IDLE, PWR_WAIT, INIT_SEQ, CMD, WAIT, DONE} top_st_e;
  typedef enum logic [2:0] {BW_IDLE, SETUP, E_HI, E_HOLD, GAP} bw_st_e;
  typedef enum logic [2:0] {OP_RST, OP_CLR, OP_HOME, OP_ADDR, OP_DATA} op_e;

  typedef struct packed {
    logic          is_byte; // 0: single nibble in dat[3:0]
    logic          rs;
    logic [7:0]    dat;
    logic [CW-1:0] wcyc;    // post-write wait in cycles
  } bw_req_t;

  // Long waits are shortened by div for simulation. Never below T_SU so the
  // data bus is still held for the full hold time after the last E fall.
  function automatic logic [CW-1:0] wscale(int unsigned t, int unsigned div);
    int unsigned v;
    v = (t >= 2000) ? t / div : t;
    if (v < T_SU) v = T_SU;
    return v[CW-1:0];
  endfunction

  // Power-on sequence after the initial settle, steps 0..7
  function automatic bw_req_t init_step(logic [3:0] s, int unsigned div);
    bw_req_t r;
    r.is_byte = 1'b1;
    r.rs      = 1'b0;
    r.dat     = CMD_CLEAR;
    r.wcyc    = wscale(T_40US, div);
    case (s)
      4'd0: begin r.is_byte = 1'b0; r.dat = 8'h03; r.wcyc = wscale(T_4MS, div);   end
      4'd1: begin r.is_byte = 1'b0; r.dat = 8'h03; r.wcyc = wscale(T_100US, div); end
      4'd2: begin r.is_byte = 1'b0; r.dat = 8'h03; end
      4'd3: begin r.is_byte = 1'b0; r.dat = 8'h02; end
      4'd4: r.dat = CMD_FUNC;
      4'd5: r.dat = CMD_ENTRY;
      4'd6: r.dat = CMD_DISP;
      default: r.wcyc = wscale(T_1MS64, div);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_nibble_driver_byte_writer.sv
// Nibble/byte write engine: setup, E pulse, hold, inter-nibble gap and the
// post-write wait. done pulses one cycle before the wait expires so the
// caller's DONE cycle lines up with the final wait cycle.
module lcd_byte_writer
  import lcd_nibble_driver_pkg::*;
(
  input  logic          CCLK,
  input  logic          reset,
  input  logic          start,
  input  bw_req_t       req,
  output logic          busy,
  output logic          done,
  output logic          rs,
  output logic          e,
  output logic [3:0]    d
);

  bw_st_e        st, st_n;
  logic [CW-1:0] cnt, cnt_n, wcyc_q;
  logic [7:0]    dat_q;
  logic          rs_q, hi, hi_n, post, post_n;

  // state, counter and latched request
  always_ff @(posedge CCLK) begin
    if (reset) begin
      st     <= BW_IDLE;
      cnt    <= '0;
      hi     <= 1'b0;
      post   <= 1'b0;
      rs_q   <= 1'b0;
      dat_q  <= '0;
      wcyc_q <= '0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      hi   <= hi_n;
      post <= post_n;
      if (start && st == BW_IDLE) begin
        rs_q   <= req.rs;
        dat_q  <= req.dat;
        wcyc_q <= req.wcyc;
      end
    end
  end

  // write sequencing
  always_comb begin
    st_n   = st;
    cnt_n  = (cnt != '0) ? cnt - 1'b1 : cnt;
    hi_n   = hi;
    post_n = post;
    case (st)
      BW_IDLE: if (start) begin
        st_n   = SETUP;
        cnt_n  = CW'(T_SU - 1);
        hi_n   = req.is_byte;
        post_n = 1'b0;
      end
      SETUP: if (cnt == '0) begin
        st_n  = E_HI;
        cnt_n = CW'(T_EPW - 1);
      end
      E_HI: if (cnt == '0) begin
        if (hi) begin
          st_n  = E_HOLD;
          cnt_n = CW'(T_SU - 1);
        end else begin
          // last nibble: the post-write wait doubles as the data hold time
          st_n   = GAP;
          post_n = 1'b1;
          cnt_n  = wcyc_q - 1'b1;
        end
      end
      E_HOLD: if (cnt == '0) begin
        st_n  = GAP;
        cnt_n = CW'(T_GAP - 1);
      end
      GAP: if (cnt == '0) begin
        if (post) begin
          st_n = BW_IDLE;
        end else begin
          st_n  = SETUP;
          hi_n  = 1'b0;
          cnt_n = CW'(T_SU - 1);
        end
      end
      default: st_n = BW_IDLE;
    endcase
  end

  assign busy = (st != BW_IDLE);
  assign done = (st == GAP) && post && (cnt == CW'(1));
  assign e    = (st == E_HI);
  assign rs   = busy & rs_q;
  assign d    = !busy ? 4'h0 : (hi ? dat_q[7:4] : dat_q[3:0]);

endmodule

// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit write-only driver: request arbitration, power-on init
// sequence and sticky per-operation done flags.
module lcd_nibble_driver
  import lcd_nibble_driver_pkg::*;
#(
  parameter int unsigned WAIT_DIV = 1
) (
  input  logic       CCLK,
  input  logic       reset,
  input  logic       resetlcd,
  input  logic       clearlcd,
  input  logic       homelcd,
  input  logic       addrlcd,
  input  logic       datalcd,
  input  logic       initlcd,
  input  logic [7:0] lcddatin,
  output logic       lcdreset,
  output logic       lcdclear,
  output logic       lcdhome,
  output logic       lcdaddr,
  output logic       lcddata,
  output logic       rslcd,
  output logic       rwlcd,
  output logic       elcd,
  output logic [3:0] lcdd
);

  localparam logic [CW-1:0] W_PWR = wscale(T_PWR, WAIT_DIV);

  top_st_e       st, st_n;
  op_e           op, op_n;
  logic [3:0]    step, step_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    cmd_q, cmd_n;
  logic          rs_q, rs_n;
  logic [4:0]    flg;
  logic          ready, set_flg;
  logic          start, bw_busy, bw_done;
  bw_req_t       req;

  // state, captured operand, done flags and ready
  always_ff @(posedge CCLK) begin
    if (reset) begin
      st    <= IDLE;
      op    <= OP_RST;
      step  <= '0;
      cnt   <= '0;
      cmd_q <= '0;
      rs_q  <= 1'b0;
      flg   <= '0;
      ready <= 1'b0;
    end else begin
      st    <= st_n;
      op    <= op_n;
      step  <= step_n;
      cnt   <= cnt_n;
      cmd_q <= cmd_n;
      rs_q  <= rs_n;
      // a set in the same cycle as initlcd wins
      flg   <= (initlcd ? 5'b0 : flg) | (set_flg ? (5'b1 << op) : 5'b0);
      ready <= ready | (set_flg && op == OP_RST);
    end
  end

  // arbitration and sequencing
  always_comb begin
    st_n        = st;
    op_n        = op;
    step_n      = step;
    cnt_n       = (cnt != '0) ? cnt - 1'b1 : cnt;
    cmd_n       = cmd_q;
    rs_n        = rs_q;
    start       = 1'b0;
    set_flg     = 1'b0;
    req.is_byte = 1'b1;
    req.rs      = rs_q;
    req.dat     = cmd_q;
    req.wcyc    = (op == OP_CLR || op == OP_HOME) ? wscale(T_1MS64, WAIT_DIV)
                                                  : wscale(T_40US, WAIT_DIV);
    case (st)
      IDLE: begin
        if (resetlcd && !flg[OP_RST]) begin
          op_n   = OP_RST;
          st_n   = PWR_WAIT;
          cnt_n  = W_PWR - 1'b1;
          step_n = '0;
        end else if (ready) begin
          if (clearlcd && !flg[OP_CLR]) begin
            op_n = OP_CLR;  cmd_n = CMD_CLEAR; rs_n = 1'b0; st_n = CMD;
          end else if (homelcd && !flg[OP_HOME]) begin
            op_n = OP_HOME; cmd_n = CMD_HOME;  rs_n = 1'b0; st_n = CMD;
          end else if (addrlcd && !flg[OP_ADDR]) begin
            op_n = OP_ADDR; cmd_n = CMD_ADDR | {1'b0, lcddatin[6:0]}; rs_n = 1'b0; st_n = CMD;
          end else if (datalcd && !flg[OP_DATA]) begin
            op_n = OP_DATA; cmd_n = lcddatin; rs_n = 1'b1; st_n = CMD;
          end
        end
      end
      PWR_WAIT: if (cnt == '0) st_n = INIT_SEQ;
      INIT_SEQ: if (!bw_busy) begin
        start = 1'b1;
        req   = init_step(step, WAIT_DIV);
        st_n  = WAIT;
      end
      CMD: if (!bw_busy) begin
        start = 1'b1;
        st_n  = WAIT;
      end
      WAIT: if (bw_done) begin
        if (op == OP_RST && step != 4'd7) begin
          step_n = step + 4'd1;
          st_n   = INIT_SEQ;
        end else begin
          if (op == OP_RST) step_n = 4'd8;
          st_n = DONE;
        end
      end
      DONE: begin
        set_flg = 1'b1;
        st_n    = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  lcd_byte_writer u_bw (
    .CCLK  (CCLK),
    .reset (reset),
    .start (start),
    .req   (req),
    .busy  (bw_busy),
    .done  (bw_done),
    .rs    (rslcd),
    .e     (elcd),
    .d     (lcdd)
  );

  assign rwlcd    = 1'b0;
  assign lcdreset = flg[OP_RST];
  assign lcdclear = flg[OP_CLR];
  assign lcdhome  = flg[OP_HOME];
  assign lcdaddr  = flg[OP_ADDR];
  assign lcddata  = flg[OP_DATA];

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Scoreboard bench: expected E-pulse nibbles are queued when a request is
// raised and popped by a monitor at every E rise.
module tb_lcd_nibble_driver;

  localparam int unsigned DIV = 1000;

  logic       CCLK, reset;
  logic       resetlcd, clearlcd, homelcd, addrlcd, datalcd, initlcd;
  logic [7:0] lcddatin;
  logic       lcdreset, lcdclear, lcdhome, lcdaddr, lcddata;
  logic       rslcd, rwlcd, elcd;
  logic [3:0] lcdd;

  lcd_nibble_driver #(.WAIT_DIV(DIV)) dut (
    .CCLK(CCLK), .reset(reset),
    .resetlcd(resetlcd), .clearlcd(clearlcd), .homelcd(homelcd),
    .addrlcd(addrlcd), .datalcd(datalcd), .initlcd(initlcd),
    .lcddatin(lcddatin),
    .lcdreset(lcdreset), .lcdclear(lcdclear), .lcdhome(lcdhome),
    .lcdaddr(lcdaddr), .lcddata(lcddata),
    .rslcd(rslcd), .rwlcd(rwlcd), .elcd(elcd), .lcdd(lcdd)
  );

  typedef struct { logic rs; logic [3:0] nib; } exp_t;
  exp_t exp_q[$];
  exp_t mx;

  int n_chk = 0, n_err = 0;
  int cyc = 0, rise_cnt = 0, fall_cnt = 0, e_w = 0;
  int last_fall_cyc = 0, last_gap = 0, flag_cyc = 0;
  bit e_prv = 0, aborting = 0;

  initial CCLK = 0;
  always #5 CCLK = ~CCLK;
  always @(posedge CCLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back('{rs, b[7:4]});
    exp_q.push_back('{rs, b[3:0]});
  endtask

  task automatic push_nib(input logic [3:0] n);
    exp_q.push_back('{1'b0, n});
  endtask

  // bus monitor: nibble/rs at each E rise, E width at each fall
  always @(negedge CCLK) begin
    if (elcd && !e_prv) begin
      rise_cnt++;
      last_gap = cyc - last_fall_cyc;
      chk("e_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mx = exp_q.pop_front();
        chk("e_rs", rslcd, mx.rs);
        chk("e_nib", lcdd, mx.nib);
      end
      chk("e_rw", rwlcd, 0);
    end
    if (elcd) e_w++;
    if (!elcd && e_prv) begin
      fall_cnt++;
      last_fall_cyc = cyc;
      if (!aborting) chk("e_width", e_w, 12);
      e_w = 0;
    end
    e_prv = elcd;
  end

  task automatic wait_flag(input int idx, input string tag, input int budget);
    logic [4:0] f;
    int n;
    n = 0;
    f = {lcddata, lcdaddr, lcdhome, lcdclear, lcdreset};
    while (!f[idx] && n < budget) begin
      @(negedge CCLK); #1;
      f = {lcddata, lcdaddr, lcdhome, lcdclear, lcdreset};
      n++;
    end
    flag_cyc = cyc;
    chk(tag, f[idx], 1);
  endtask

  task automatic wait_ev(input bit fall, input int target, input string tag);
    int n;
    n = 0;
    while (((fall ? fall_cnt : rise_cnt) < target) && n < 3000) begin
      @(negedge CCLK); #1;
      n++;
    end
    chk(tag, ((fall ? fall_cnt : rise_cnt) >= target), 1);
  endtask

  task automatic pulse_init();
    @(negedge CCLK); initlcd = 1;
    @(negedge CCLK); initlcd = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0;
    reset = 1; resetlcd = 0; clearlcd = 0; homelcd = 0; addrlcd = 0;
    datalcd = 0; initlcd = 0; lcddatin = 8'h00;
    repeat (3) @(negedge CCLK);
    chk("rst_outs", {rslcd, rwlcd, elcd, lcdd, lcdreset, lcdclear, lcdhome, lcdaddr, lcddata}, 0);
    reset = 0;

    // requests before init are ignored
    r0 = rise_cnt;
    clearlcd = 1; datalcd = 1; lcddatin = 8'h37;
    repeat (200) @(negedge CCLK);
    chk("preinit_no_e", rise_cnt - r0, 0);
    chk("preinit_flags", {lcdclear, lcddata}, 0);
    clearlcd = 0; datalcd = 0;

    // power-on init sequence
    push_nib(4'h3); push_nib(4'h3); push_nib(4'h3); push_nib(4'h2);
    push_byte(0, 8'h28); push_byte(0, 8'h06); push_byte(0, 8'h0C); push_byte(0, 8'h01);
    resetlcd = 1;
    wait_flag(0, "init_done", 5000);
    resetlcd = 0;
    chk("init_all_e", exp_q.size(), 0);

    // clear beats data when raised together
    pulse_init();
    chk("initlcd_clr", lcdreset, 0);
    lcddatin = 8'h37;
    push_byte(0, 8'h01); push_byte(1, 8'h37);
    clearlcd = 1; datalcd = 1;
    wait_flag(1, "prio_clear", 2000);
    chk("prio_data_after", lcddata, 0);
    clearlcd = 0;
    wait_flag(4, "prio_data", 2000);
    datalcd = 0;

    // data write, operand changed mid-flight, then held request
    pulse_init();
    chk("init_flags", {lcdclear, lcddata}, 0);
    lcddatin = 8'h41;
    push_byte(1, 8'h41);
    r0 = rise_cnt;
    datalcd = 1;
    wait_ev(0, r0 + 1, "data_hi_rise");
    lcddatin = 8'hFF;
    wait_flag(4, "data_done", 2000);
    chk("data_lat", flag_cyc - last_fall_cyc, 2);
    chk("data_gap", last_gap, 54);  // hold 2 + gap 50 + setup 2
    r0 = rise_cnt;
    repeat (5000) @(negedge CCLK);
    chk("held_once", rise_cnt - r0, 0);
    chk("held_flag", lcddata, 1);
    datalcd = 0;

    // addr write, with initlcd landing on the flag-set edge
    lcddatin = 8'hC5;
    push_byte(0, 8'hC5);
    f0 = fall_cnt;
    addrlcd = 1;
    wait_ev(1, f0 + 2, "addr_falls");
    @(negedge CCLK); initlcd = 1;
    @(negedge CCLK); initlcd = 0;
    chk("coinc_addr", lcdaddr, 1);
    chk("coinc_data_clr", lcddata, 0);
    addrlcd = 0;

    // reset during E high of the low data nibble
    pulse_init();
    lcddatin = 8'h41;
    push_byte(1, 8'h41);
    r0 = rise_cnt;
    datalcd = 1;
    wait_ev(0, r0 + 2, "abort_lo_rise");
    aborting = 1;
    reset = 1;
    @(negedge CCLK);
    chk("abort_outs", {rslcd, rwlcd, elcd, lcdd, lcdreset, lcdclear, lcdhome, lcdaddr, lcddata}, 0);
    reset = 0;
    r0 = rise_cnt;
    repeat (300) @(negedge CCLK);
    chk("abort_no_e", rise_cnt - r0, 0);
    chk("abort_no_flag", lcddata, 0);
    datalcd = 0;
    aborting = 0;

    chk("q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
